// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one fixed-latency memory between
// the CPU and a debug/loader port; one access at a time with a per-port ack.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    input  logic          dbg_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic       GNT_CPU = 1'b0;
    localparam logic       GNT_DBG = 1'b1;
    localparam logic [2:0] LAT_LD  = 3'(MEM_LAT);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_grant;
    logic       gnt;
    logic       we_lat;
    logic       cpu_elig;
    logic       dbg_elig;
    logic       grant_any;
    logic       pick;
    logic       capture;

    always_comb begin
        cpu_elig  = cpu_req & ~dbg_lock;
        dbg_elig  = dbg_req;
        grant_any = cpu_elig | dbg_elig;
        // On a tie the port not granted last wins; otherwise the lone requester.
        if (cpu_elig && dbg_elig) begin
            pick = ~last_grant;
        end else begin
            pick = dbg_elig ? GNT_DBG : GNT_CPU;
        end
        capture   = (state == WAIT) && (cnt == 3'd1);
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 3'd0;
            last_grant <= GNT_DBG;
            gnt        <= GNT_CPU;
            we_lat     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        mem_en     <= 1'b1;
                        if (pick == GNT_DBG) begin
                            we_lat    <= dbg_we;
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end else begin
                            we_lat    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ISSUE: cnt <= LAT_LD;
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Final wait cycle: memory data is valid now; ack shows next cycle.
                    if (capture) begin
                        if (!we_lat && gnt == GNT_CPU) cpu_rdata <= mem_rdata;
                        if (!we_lat && gnt == GNT_DBG) dbg_rdata <= mem_rdata;
                        cpu_ack <= (gnt == GNT_CPU);
                        dbg_ack <= (gnt == GNT_DBG);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4), each
// with its own requesters and a latency-accurate memory model.
module tb_mem_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        cpu_req[3], cpu_we[3], dbg_req[3], dbg_we[3], dbg_lock[3];
    logic [31:0] cpu_addr[3], cpu_wdata[3], dbg_addr[3], dbg_wdata[3];
    logic [31:0] cpu_rdata[3], dbg_rdata[3], mem_addr[3], mem_wdata[3], mem_rdata[3];
    logic        cpu_ack[3], dbg_ack[3], mem_en[3], mem_we[3];
    logic [31:0] m_cpu_rd[3], m_dbg_rd[3];
    exp_t        sb[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memdata(logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        int          left = 0;
        logic [31:0] raddr = '0;

        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
            .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
            .dbg_wdata(dbg_wdata[g]), .dbg_rdata(dbg_rdata[g]), .dbg_ack(dbg_ack[g]),
            .dbg_lock(dbg_lock[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Data is valid only in the cycle L cycles after the mem_en cycle.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                left  <= L;
                raddr <= mem_addr[g];
            end else if (left != 0) begin
                left <= left - 1;
            end
        end
        assign mem_rdata[g] = (left == 1) ? memdata(raddr) : {16'hBAD0, cyc[15:0]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (cpu_ack[d] === 1'b1 || dbg_ack[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    chk("unexpected_ack", {30'd0, cpu_ack[d], dbg_ack[d]}, 32'd0);
                end else begin
                    e = sb[d].pop_front();
                    chk("ack_port", {31'd0, dbg_ack[d]}, {31'd0, e.port});
                    chk("other_ack", {31'd0, e.port ? cpu_ack[d] : dbg_ack[d]}, 32'd0);
                    chk("ack_cycle", cyc, e.cyc);
                    chk("rdata", e.port ? dbg_rdata[d] : cpu_rdata[d], e.rdata);
                end
            end
            if (mem_we[d] === 1'b1 && mem_en[d] !== 1'b1)
                chk("mem_we_without_en", {31'd0, mem_en[d]}, 32'd1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input logic port, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            dbg_req[d] = v; dbg_we[d] = we; dbg_addr[d] = addr; dbg_wdata[d] = wdata;
        end else begin
            cpu_req[d] = v; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
        end
    endtask

    task automatic push_exp(input int d, input logic port, input logic we,
                            input logic [31:0] addr, input int ack_cyc);
        exp_t e;
        e.port = port;
        e.cyc  = ack_cyc;
        if (we) begin
            e.rdata = port ? m_dbg_rd[d] : m_cpu_rd[d];
        end else begin
            e.rdata = memdata(addr);
            if (port) m_dbg_rd[d] = e.rdata;
            else      m_cpu_rd[d] = e.rdata;
        end
        sb[d].push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_mem_en", {31'd0, mem_en[d]}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we[d]}, 32'd0);
            chk("rst_mem_addr", mem_addr[d], 32'd0);
            chk("rst_mem_wdata", mem_wdata[d], 32'd0);
            chk("rst_acks", {30'd0, cpu_ack[d], dbg_ack[d]}, 32'd0);
            chk("rst_cpu_rdata", cpu_rdata[d], 32'd0);
            chk("rst_dbg_rdata", dbg_rdata[d], 32'd0);
            sb[d].delete();
            m_cpu_rd[d] = '0;
            m_dbg_rd[d] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One access from an idle DUT: req at cycle 0, checks mem strobes each cycle.
    task automatic run_access(input int d, input logic port, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic early_drop);
        int c0 = cyc;
        int l = lat(d);
        set_req(d, port, 1'b1, we, addr, wdata);
        push_exp(d, port, we, addr, c0 + 2 + l);
        for (int k = 0; k <= 2 + l; k++) begin
            chk("mem_en", {31'd0, mem_en[d]}, {31'd0, k == 1});
            if (k == 1) begin
                chk("mem_we", {31'd0, mem_we[d]}, {31'd0, we});
                chk("mem_addr", mem_addr[d], addr);
                if (we) chk("mem_wdata", mem_wdata[d], wdata);
                if (early_drop) set_req(d, port, 1'b0, we, addr, wdata);
            end
            next_cycle();
        end
        set_req(d, port, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int c0;
        for (int d = 0; d < 3; d++) begin
            set_req(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            set_req(d, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            dbg_lock[d] = 1'b0;
        end
        next_cycle();
        do_reset();
        next_cycle();

        // CPU read, MEM_LAT=1
        run_access(0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0);
        next_cycle();

        // Both ports requesting from reset: strict alternation starting with CPU
        do_reset();
        c0 = cyc;
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'd0);
        push_exp(0, 1'b0, 1'b0, 32'h20, c0 + 3);
        push_exp(0, 1'b1, 1'b0, 32'h24, c0 + 7);
        push_exp(0, 1'b0, 1'b0, 32'h20, c0 + 11);
        push_exp(0, 1'b1, 1'b0, 32'h24, c0 + 15);
        while (cyc < c0 + 12) next_cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        while (cyc < c0 + 16) next_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        chk("rr_idle_after", {31'd0, mem_en[0]}, 32'd0);
        next_cycle();

        // Debug read then write at MEM_LAT=3: write leaves dbg_rdata alone
        run_access(1, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
        next_cycle();
        run_access(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0);
        next_cycle();

        // dbg_lock blocks CPU grants until it drops
        dbg_lock[0] = 1'b1;
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h80, 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk("lock_no_en", {31'd0, mem_en[0]}, 32'd0);
            next_cycle();
        end
        dbg_lock[0] = 1'b0;
        run_access(0, 1'b0, 1'b0, 32'h80, 32'd0, 1'b0);
        next_cycle();

        // Request dropped after cycle 0 still completes
        run_access(0, 1'b0, 1'b0, 32'h84, 32'd0, 1'b1);
        next_cycle();
        run_access(2, 1'b0, 1'b0, 32'h88, 32'd0, 1'b1);
        next_cycle();

        // Reset during WAIT at MEM_LAT=4: everything clears, no ack follows
        c0 = cyc;
        set_req(2, 1'b0, 1'b1, 1'b0, 32'h90, 32'd0);
        while (cyc < c0 + 3) next_cycle();
        set_req(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_idle", {31'd0, mem_en[2]}, 32'd0);
            next_cycle();
        end
        run_access(2, 1'b0, 1'b0, 32'h30, 32'd0, 1'b0);
        run_access(2, 1'b1, 1'b0, 32'h34, 32'd0, 1'b0);
        next_cycle();

        for (int d = 0; d < 3; d++) chk("scoreboard_drain", sb[d].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
